// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD frame writer: FSM states, bus phases,
// HD44780 command bytes and small decode helpers.
package lcd_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_INIT,
      S_CLR_WAIT,
      S_SNAP,
      S_ADDR_U,
      S_ROW_U,
      S_ADDR_L,
      S_ROW_L,
      S_DONE
   } lcd_state_e;

   typedef enum logic [1:0] {
      PH_SETUP,
      PH_STROBE,
      PH_HOLD
   } lcd_phase_e;

   localparam logic [7:0] CMD_FUNC_SET = 8'h38;
   localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
   localparam logic [7:0] CMD_ENTRY    = 8'h06;
   localparam logic [7:0] CMD_CLEAR    = 8'h01;
   localparam logic [7:0] CMD_ADDR_U   = 8'h80;
   localparam logic [7:0] CMD_ADDR_L   = 8'hC0;
   localparam logic [7:0] CHAR_SPACE   = 8'h20;

   function automatic logic [7:0] init_cmd(input logic [1:0] idx);
      case (idx)
         2'd0:    init_cmd = CMD_FUNC_SET;
         2'd1:    init_cmd = CMD_DISP_ON;
         2'd2:    init_cmd = CMD_ENTRY;
         default: init_cmd = CMD_CLEAR;
      endcase
   endfunction

   // States that drive a SETUP/STROBE/HOLD bus transaction.
   function automatic logic is_xfer(input lcd_state_e s);
      is_xfer = (s == S_INIT) || (s == S_ADDR_U) || (s == S_ROW_U) ||
                (s == S_ADDR_L) || (s == S_ROW_L);
   endfunction

endpackage

// File: rtl/lcd_tick_gen.sv
// TICK_DIV prescaler: one-cycle tick_o every TICK_DIV enabled cycles; clr_i
// restarts the count from zero.
module lcd_tick_gen #(
   parameter int TICK_DIV = 50
) (
   input  logic CLK,
   input  logic RST,
   input  logic clr_i,
   input  logic en_i,
   output logic tick_o
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i)
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign tick_o = en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/lcd_frame_writer.sv
// Character-LCD writer: one-time init, then 2x16 frames from a shadow snapped at SNAP.
// Define LCD_DIRTY_SKIP_EN to skip frames whose text equals the last written shadow.
module lcd_frame_writer #(
   parameter int TICK_DIV  = 50,
   parameter int CLR_TICKS = 200
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         ENABLE,
   input  logic [127:0] TEXT_UPPER,
   input  logic [127:0] TEXT_LOWER,
   output logic         TLCD_E,
   output logic         TLCD_RS,
   output logic         TLCD_RW,
   output logic [7:0]   TLCD_DATA,
   output logic         BUSY,
   output logic         FRAME_DONE
);
   import lcd_pkg::*;

   localparam int WW = (CLR_TICKS > 1) ? $clog2(CLR_TICKS) : 1;

   lcd_state_e       state_q, state_d;
   lcd_phase_e       phase_q, phase_d;
   logic [3:0]       col_q, col_d;
   logic [WW-1:0]    wait_q, wait_d;
   logic             init_done_q, init_done_d;
   logic [31:0][7:0] shadow_q, shadow_d;
   logic             e_q, e_d;
   logic             tick;
   logic             xfer_end;
   logic             bus_rs;
   logic [7:0]       bus_data;
`ifdef LCD_DIRTY_SKIP_EN
   logic             written_q, written_d;
`endif

   lcd_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .CLK   (CLK),
      .RST   (RST),
      .clr_i (state_q == S_IDLE),
      .en_i  (state_q != S_IDLE),
      .tick_o(tick)
   );

   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      col_d       = col_q;
      wait_d      = wait_q;
      init_done_d = init_done_q;
      shadow_d    = shadow_q;
`ifdef LCD_DIRTY_SKIP_EN
      written_d   = written_q;
`endif
      xfer_end    = 1'b0;

      if (is_xfer(state_q) && tick) begin
         case (phase_q)
            PH_SETUP:  phase_d = PH_STROBE;
            PH_STROBE: phase_d = PH_HOLD;
            default: begin
               phase_d  = PH_SETUP;
               xfer_end = 1'b1;
            end
         endcase
      end

      case (state_q)
         S_IDLE:
            if (ENABLE) state_d = init_done_q ? S_SNAP : S_INIT;
         S_INIT:
            // col_q doubles as the init command index; it leaves INIT at 0.
            if (xfer_end) begin
               col_d = col_q + 4'd1;
               if (col_q == 4'd3) begin
                  col_d   = '0;
                  wait_d  = '0;
                  state_d = S_CLR_WAIT;
               end
            end
         S_CLR_WAIT:
            if (tick) begin
               if (wait_q == WW'(CLR_TICKS - 1)) begin
                  init_done_d = 1'b1;
                  state_d     = S_SNAP;
               end else begin
                  wait_d = wait_q + 1'b1;
               end
            end
         S_SNAP: begin
            shadow_d = {TEXT_UPPER, TEXT_LOWER};
            state_d  = S_ADDR_U;
`ifdef LCD_DIRTY_SKIP_EN
            if (written_q && ({TEXT_UPPER, TEXT_LOWER} == shadow_q))
               state_d = S_IDLE;
`endif
         end
         S_ADDR_U:
            if (xfer_end) state_d = S_ROW_U;
         S_ROW_U:
            if (xfer_end) begin
               col_d = col_q + 4'd1;
               if (col_q == 4'd15) state_d = S_ADDR_L;
            end
         S_ADDR_L:
            if (xfer_end) state_d = S_ROW_L;
         S_ROW_L:
            if (xfer_end) begin
               col_d = col_q + 4'd1;
               if (col_q == 4'd15) state_d = S_DONE;
            end
         S_DONE: begin
            state_d = S_IDLE;
`ifdef LCD_DIRTY_SKIP_EN
            written_d = 1'b1;
`endif
         end
         default: state_d = S_IDLE;
      endcase

      e_d = (phase_d == PH_STROBE);
   end

   // Shadow byte {row, ~col}: upper row occupies bytes 31..16, column 0 highest.
   always_comb begin
      bus_rs   = 1'b0;
      bus_data = 8'h00;
      case (state_q)
         S_INIT:   bus_data = init_cmd(col_q[1:0]);
         S_ADDR_U: bus_data = CMD_ADDR_U;
         S_ROW_U: begin
            bus_rs   = 1'b1;
            bus_data = shadow_q[{1'b1, ~col_q}];
         end
         S_ADDR_L: bus_data = CMD_ADDR_L;
         S_ROW_L: begin
            bus_rs   = 1'b1;
            bus_data = shadow_q[{1'b0, ~col_q}];
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= S_IDLE;
         phase_q     <= PH_SETUP;
         col_q       <= '0;
         wait_q      <= '0;
         init_done_q <= 1'b0;
         shadow_q    <= {32{CHAR_SPACE}};
         e_q         <= 1'b0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         col_q       <= col_d;
         wait_q      <= wait_d;
         init_done_q <= init_done_d;
         shadow_q    <= shadow_d;
         e_q         <= e_d;
      end
   end

`ifdef LCD_DIRTY_SKIP_EN
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         written_q <= 1'b0;
      else
         written_q <= written_d;
   end
`endif

   assign TLCD_E     = e_q;
   assign TLCD_RS    = bus_rs;
   assign TLCD_RW    = 1'b0;
   assign TLCD_DATA  = bus_data;
   assign BUSY       = (state_q != S_IDLE);
   assign FRAME_DONE = (state_q == S_DONE);

endmodule

// File: tb/tb_lcd_frame_writer.sv
// Bench for lcd_frame_writer: a transaction-level model (expected bus bytes queue)
// checked on every strobe, plus directed literal expectations.
module tb_lcd_frame_writer;

   localparam int DIV  = 2;
   localparam int CLR  = 200;
   localparam int MARK = -1;

   localparam logic [127:0] T_GAME = "GAME OVER       ";
   localparam logic [127:0] T_LO1  = "Hello, world!!!!";
   localparam logic [127:0] T_UP2  = "SCORE 0000012345";
   localparam logic [127:0] T_LO2  = "PRESS START     ";
   localparam logic [127:0] T_UP4  = "LEVEL 2         ";

   logic         CLK = 1'b0;
   logic         RST;
   logic         ENABLE;
   logic [127:0] TEXT_UPPER, TEXT_LOWER;
   logic         TLCD_E, TLCD_RS, TLCD_RW, BUSY, FRAME_DONE;
   logic [7:0]   TLCD_DATA;

   int n_cmp = 0;
   int n_err = 0;
   int exp_q[$];
   int log_v[$];
   int log_t[$];
   int frame_cnt = 0;

   lcd_frame_writer #(.TICK_DIV(DIV), .CLR_TICKS(CLR)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .ENABLE    (ENABLE),
      .TEXT_UPPER(TEXT_UPPER),
      .TEXT_LOWER(TEXT_LOWER),
      .TLCD_E    (TLCD_E),
      .TLCD_RS   (TLCD_RS),
      .TLCD_RW   (TLCD_RW),
      .TLCD_DATA (TLCD_DATA),
      .BUSY      (BUSY),
      .FRAME_DONE(FRAME_DONE)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
      n_cmp++;
      if (act < lo || act > hi) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d..%0d", nm, act, lo, hi);
      end
   endtask

   // Expected bus entries: {RS, DATA}; MARK stands for the FRAME_DONE pulse.
   task automatic push_init();
      exp_q.push_back('h038);
      exp_q.push_back('h00C);
      exp_q.push_back('h006);
      exp_q.push_back('h001);
   endtask

   task automatic push_frame(input logic [127:0] up, input logic [127:0] lo);
      exp_q.push_back('h080);
      for (int c = 0; c < 16; c++) exp_q.push_back(256 + int'(up[127-8*c -: 8]));
      exp_q.push_back('h0C0);
      for (int c = 0; c < 16; c++) exp_q.push_back(256 + int'(lo[127-8*c -: 8]));
      exp_q.push_back(MARK);
   endtask

   task automatic wait_done(input string nm, input int budget);
      int n;
      n = 0;
      do begin
         @(posedge CLK); #1;
         n++;
      end while (!FRAME_DONE && n < budget);
      chk(nm, FRAME_DONE, 1);
   endtask

   task automatic wait_log(input string nm, input int target, input int budget);
      int n;
      n = 0;
      while (log_v.size() < target && n < budget) begin
         @(posedge CLK); #1;
         n++;
      end
      chk_rng(nm, log_v.size(), target, 1 << 30);
   endtask

   // Compare process: every strobe is matched against the model queue.
   int          cyc = 0;
   int          last_rise = 0;
   int          hi_cnt = 0;
   int          head;
   logic        e_prev = 1'b0, fd_prev = 1'b0, have_rise = 1'b0;
   logic [31:0] act, rise_val;

   always @(negedge CLK) begin
      act  = {23'd0, TLCD_RS, TLCD_DATA};
      head = (exp_q.size() > 0) ? exp_q[0] : -2;
      if (RST) begin
         e_prev    = 1'b0;
         fd_prev   = 1'b0;
         have_rise = 1'b0;
         hi_cnt    = 0;
      end else begin
         chk("rw_low", TLCD_RW, 0);
         if (TLCD_E && !e_prev) begin
            chk("bus", act, head);
            if (head >= 0) void'(exp_q.pop_front());
            if (have_rise) chk_rng("e_spacing", cyc - last_rise, 3*DIV, 1 << 30);
            last_rise = cyc;
            have_rise = 1'b1;
            rise_val  = act;
            hi_cnt    = 0;
            log_v.push_back(int'(act));
            log_t.push_back(cyc);
         end
         if (TLCD_E) hi_cnt++;
         if (!TLCD_E && e_prev) begin
            chk("e_width", hi_cnt, DIV);
            chk("bus_hold", act, rise_val);
         end
         if (FRAME_DONE) begin
            chk("done_width", fd_prev, 0);
            chk("done_order", head, MARK);
            if (head == MARK) void'(exp_q.pop_front());
            frame_cnt++;
         end
         e_prev  = TLCD_E;
         fd_prev = FRAME_DONE;
      end
      cyc++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, n;
      RST = 1'b1; ENABLE = 1'b0;
      TEXT_UPPER = T_GAME; TEXT_LOWER = T_LO1;
      repeat (3) @(posedge CLK); #1;
      chk("rst_e", TLCD_E, 0);
      chk("rst_rs", TLCD_RS, 0);
      chk("rst_rw", TLCD_RW, 0);
      chk("rst_data", TLCD_DATA, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_done", FRAME_DONE, 0);
      RST = 1'b0;
      repeat (5) @(posedge CLK); #1;
      chk("idle_busy", BUSY, 0);
      chk("idle_quiet", log_v.size(), 0);

      // Init then first frame.
      push_init();
      push_frame(T_GAME, T_LO1);
      ENABLE = 1'b1;
      wait_done("frame1_done", 3000);
      chk("init0", log_v[0], 'h038);
      chk("init1", log_v[1], 'h00C);
      chk("init2", log_v[2], 'h006);
      chk("init3", log_v[3], 'h001);
      chk("addr_u", log_v[4], 'h080);
      chk("row_u0", log_v[5], 'h147);
      chk("row_u1", log_v[6], 'h141);
      chk("row_u2", log_v[7], 'h14D);
      chk("row_u3", log_v[8], 'h145);
      chk("row_u4", log_v[9], 'h120);
      chk("addr_l", log_v[21], 'h0C0);
      chk_rng("clr_wait_gap", log_t[4] - log_t[3], (CLR+3)*DIV, (CLR+4)*DIV);

      // Frame 2: new upper before SNAP, lower changed mid ROW_U must not tear.
      TEXT_UPPER = T_UP2;
      push_frame(T_UP2, T_LO1);
      push_frame(T_UP2, T_LO2);
      base = log_v.size();
      wait_log("f2_row_u", base + 6, 1000);
      chk("f2_busy", BUSY, 1);
      TEXT_LOWER = T_LO2;
      wait_done("frame2_done", 1000);
      chk("f2_addr_l", log_v[base+17], 'h0C0);
      chk("f2_no_tear", log_v[base+18], 'h148);

      // Frame 3: drop ENABLE at byte 5 of ROW_L; frame finishes, then parks.
      base = log_v.size();
      wait_log("f3_row_l5", base + 23, 1000);
      ENABLE = 1'b0;
      wait_done("frame3_done", 1000);
      chk("f3_new_lower", log_v[base+18], 'h150);
      repeat (3) @(posedge CLK); #1;
      chk("park_busy", BUSY, 0);
      repeat (300) @(posedge CLK); #1;
      chk("park_quiet", log_v.size(), base + 34);
      chk("park_drained", exp_q.size(), 0);
      chk("park_frames", frame_cnt, 3);

      // Frame 4 aborted by reset during a strobe; init must rerun.
      TEXT_UPPER = T_UP4;
      push_frame(T_UP4, T_LO2);
      ENABLE = 1'b1;
      base = log_v.size();
      wait_log("f4_started", base + 3, 1000);
      n = 0;
      while (!TLCD_E && n < 100) begin
         @(posedge CLK); #1;
         n++;
      end
      chk("e_before_rst", TLCD_E, 1);
      #2 RST = 1'b1;
      #1;
      chk("rst_async_e", TLCD_E, 0);
      chk("rst_async_busy", BUSY, 0);
      chk("rst_async_data", TLCD_DATA, 0);
      exp_q.delete();
      repeat (2) @(posedge CLK); #1;
      RST = 1'b0;
      base = log_v.size();
      push_init();
      push_frame(T_UP4, T_LO2);
      wait_done("rst_frame_done", 3000);
      chk("reinit0", log_v[base], 'h038);
      chk("reinit_addr", log_v[base+4], 'h080);
      chk("reinit_row", log_v[base+5], 'h14C);

`ifdef LCD_DIRTY_SKIP_EN
      // Unchanged text: no strobes, no FRAME_DONE; one byte change restores a frame.
      n = frame_cnt;
      base = log_v.size();
      repeat (400) @(posedge CLK); #1;
      chk("skip_quiet", log_v.size(), base);
      chk("skip_no_done", frame_cnt, n);
      TEXT_LOWER[7:0] = 8'h3F;
      push_frame(T_UP4, TEXT_LOWER);
      wait_done("dirty_frame_done", 1000);
      chk("dirty_full", log_v.size() - base, 34);
`endif

      ENABLE = 1'b0;
      repeat (20) @(posedge CLK); #1;
      chk("final_drained", exp_q.size(), 0);
      chk("final_busy", BUSY, 0);
`ifdef LCD_DIRTY_SKIP_EN
      chk("final_frames", frame_cnt, 5);
`else
      chk("final_frames", frame_cnt, 4);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/lcd_frame_writer.md
LCD_FRAME_WRITER -- requirements
Module: lcd_frame_writer

Interface
REQ-001 Parameter TICK_DIV, default 50: CLK cycles per LCD timing tick.
REQ-002 Parameter CLR_TICKS, default 200: idle ticks required after the Clear Display command.
REQ-003 CLK  input  1  system clock; all logic rising-edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 ENABLE  input  1  level request to keep refreshing the panel.
REQ-006 TEXT_UPPER  input  128  row 0 characters; bits [127:120] = column 0, [7:0] = column 15.
REQ-007 TEXT_LOWER  input  128  row 1 characters, same byte ordering.
REQ-008 TLCD_E  output  1  LCD enable strobe.
REQ-009 TLCD_RS  output  1  0 = command, 1 = data.
REQ-010 TLCD_RW  output  1  read/write select; always 0 (write only).
REQ-011 TLCD_DATA  output  8  LCD data bus.
REQ-012 BUSY  output  1  high whenever the FSM is not in IDLE.
REQ-013 FRAME_DONE  output  1  one-CLK pulse after the last character of a frame is written.

Function
REQ-014 A tick is one CLK cycle out of every TICK_DIV cycles; the tick counter runs only while BUSY is high and restarts at 0 on leaving IDLE.
REQ-015 Each LCD transaction takes 3 ticks: SETUP (E=0, RS/DATA valid), STROBE (E=1), HOLD (E=0, RS/DATA unchanged).
REQ-016 FSM states: IDLE, INIT, CLR_WAIT, SNAP, ADDR_U, ROW_U, ADDR_L, ROW_L, DONE.
REQ-017 IDLE -> INIT on ENABLE=1 when init_done=0; IDLE -> SNAP on ENABLE=1 when init_done=1.
REQ-018 INIT issues commands 0x38, 0x0C, 0x06, 0x01 in that order, enters CLR_WAIT for CLR_TICKS ticks, then sets init_done=1 and goes to SNAP.
REQ-019 SNAP latches TEXT_UPPER and TEXT_LOWER into a 256-bit shadow in one CLK; input changes during the rest of the frame are ignored (no tearing).
REQ-020 ADDR_U writes command 0x80; ROW_U writes 16 data bytes, columns 0..15 in order; ADDR_L writes 0xC0; ROW_L writes 16 data bytes.
REQ-021 A frame from SNAP to DONE is 34 transactions = 102 ticks.
REQ-022 DONE pulses FRAME_DONE for exactly 1 CLK and then returns to IDLE; if ENABLE is still 1, the next frame starts at SNAP on the following cycle.
REQ-023 Deasserting ENABLE mid-frame or mid-init does not abort; the current sequence completes, then the FSM parks in IDLE.
REQ-024 The column counter is 4 bits and wraps 15 -> 0 only when the row transition fires; no other wrap is legal.
REQ-025 TLCD_E is never high in two consecutive ticks.

Reset
REQ-026 On RST: state=IDLE, init_done=0, shadow=all 0x20, tick and column counters=0, TLCD_E=0, TLCD_RS=0, TLCD_RW=0, TLCD_DATA=0x00, BUSY=0, FRAME_DONE=0.
REQ-027 RST asserted mid-transaction drops TLCD_E low asynchronously; after release, the full INIT sequence reruns.

Configuration
REQ-028 Macro LCD_DIRTY_SKIP_EN defined: SNAP compares the new inputs with the last written shadow; if they are equal and a frame has completed since reset, the FSM returns to IDLE with no bus activity and no FRAME_DONE pulse.
REQ-029 Macro LCD_DIRTY_SKIP_EN undefined: every SNAP performs a full write, giving continuous refresh.

Structure
REQ-030 Package lcd_pkg holds the FSM state enum, the command constants (0x38, 0x0C, 0x06, 0x01, 0x80, 0xC0) and the space character 0x20.
REQ-031 One sub-module, lcd_tick_gen, holds the TICK_DIV prescaler with a synchronous clear and a one-cycle tick output.

Verification
REQ-032 RST, then ENABLE=1, TICK_DIV=2 -> bus shows 0x38, 0x0C, 0x06, 0x01 (RS=0), 200 idle ticks, 0x80, then 16 RS=1 bytes.
REQ-033 TEXT_UPPER="GAME OVER       " -> ROW_U bytes 0x47, 0x41, 0x4D, 0x45, 0x20, ... in column order; FRAME_DONE pulses once after byte 32.
REQ-034 Change TEXT_LOWER during ROW_U -> the lower row written equals the value latched at SNAP; the new value appears in the next frame.
REQ-035 Drop ENABLE at byte 5 of ROW_L -> the remaining bytes are still written, FRAME_DONE pulses, then BUSY=0 and the bus stays idle.
REQ-036 With LCD_DIRTY_SKIP_EN, hold the inputs constant for 2 frames -> the second SNAP produces no TLCD_E pulses; changing one byte restores a full 34-transaction frame.
REQ-037 Assert RST during STROBE -> TLCD_E=0 within the same cycle; after release, INIT repeats from 0x38.
